fsm1_rd_arbiter: RTL
====================

FSM1_RD_ARBITER -- requirements
Module: fsm1_rd_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter MAX_WS, default 15: maximum consecutive wait-state retries per transaction, legal range 1..255.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 req  input  NREQ  per-requester read request, level; bit i belongs to requester i.
REQ-006 ws  input  1  wait state from the shared read resource, sampled only in DLY.
REQ-007 gnt  output  NREQ  one-hot grant; all zero outside a transaction.
REQ-008 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 rd  output  1  read strobe to the shared resource.
REQ-010 ds  output  1  data-strobe / transaction-done indication.
REQ-011 tout  output  1  one-cycle pulse, coincident with ds, when a transaction ends by retry limit.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Control FSM states: IDLE, READ, DLY, DONE; one-hot encoded; all outputs decoded directly from flops (no combinational path from any input to any output).
REQ-014 IDLE: any req bit high -> READ, latching the arbitration winner into gnt; no req -> stay IDLE.
REQ-015 READ -> DLY unconditionally.
REQ-016 DLY: ws=1 and wcnt<MAX_WS -> READ with wcnt+1; ws=1 and wcnt==MAX_WS -> DONE with tout flagged; ws=0 -> DONE.
REQ-017 DONE -> IDLE unconditionally.
REQ-018 rd=1 in READ and DLY; ds=1 in DONE only; outputs equal those of the single-master fsm1 sequence for the same go/ws stimulus, with go = OR of req.
REQ-019 gnt holds the latched one-hot winner from READ through DONE inclusive, unchanged regardless of req activity.
REQ-020 done = gnt while in DONE, else zero.
REQ-021 Arbitration: round-robin; search starts at pointer ptr and proceeds ptr, ptr+1, ... wrapping modulo NREQ; first asserted bit wins.
REQ-022 ptr updates to (winner+1) mod NREQ on the IDLE->READ transition only.
REQ-023 wcnt width = clog2(MAX_WS+1); cleared on IDLE->READ; never wraps.
REQ-024 Minimum transaction: 4 cycles (READ, DLY, DONE, IDLE); a request present in IDLE enters READ on the next edge.
REQ-025 Requester deasserting req after grant: ignored; transaction completes normally and done still pulses.
REQ-026 Requester holding req high through DONE: eligible again in the following IDLE cycle, subject to round-robin order.
REQ-027 ws is don't-care in IDLE, READ and DONE.

Reset
REQ-028 RST_N low asynchronously forces: state=IDLE, gnt=0, done=0, rd=0, ds=0, tout=0, busy=0, ptr=0, wcnt=0.
REQ-029 Reset asserted mid-transaction aborts it with no done or ds pulse; first grant after release follows ptr=0.
REQ-030 First arbitration occurs on the first rising edge with RST_N high.

Verification
REQ-031 Single request: req=4'b0010, ws=0 -> gnt=0010 for 3 cycles, rd high 2 cycles (READ, DLY), ds and done[1] high in the third cycle, tout=0, then IDLE.
REQ-032 Wait states: req=4'b0001, ws=1 for first 2 DLY visits then 0 -> state sequence READ,DLY,READ,DLY,READ,DLY,DONE; rd high 6 cycles; done[0] pulses once.
REQ-033 Round-robin fairness: req=4'b1111 held, ws=0 -> grant order 0,1,2,3,0,1, one grant per 4 cycles, done pulses in matching order.
REQ-034 Retry limit: MAX_WS=3, req=4'b0100, ws held 1 -> 4 DLY visits, then DONE with ds=1, done[2]=1, tout=1 for one cycle; next transaction with ws=0 gives tout=0.
REQ-035 Reset mid-transaction: assert RST_N low during DLY of grant to requester 2 -> all outputs 0 immediately, no done pulse; after release with req=4'b1100 -> grant goes to requester 2 (ptr=0 search order).
REQ-036 Bench compares rd/ds against an instance of the single-master fsm1 driven with go=|req and the same ws, asserting equality every cycle.

Source files
------------

// File: rtl/fsm1_rd_arbiter.sv
// -----------------------------------------------------------------------------
// fsm1_rd_arbiter
//
// Round-robin arbiter in front of a single read-sequencing FSM. Up to NREQ
// requesters share one read resource. A transaction always runs
// IDLE -> READ -> DLY -> (READ -> DLY)* -> DONE -> IDLE. The resource may
// stretch it with wait states (ws) for at most MAX_WS retries.
//
// Ports
//   CLK        in   rising-edge clock
//   RST_N      in   asynchronous active-low reset
//   req        in   [NREQ]  level read request per requester
//   ws         in   wait state from the shared resource, used only in DLY
//   gnt        out  [NREQ]  one-hot grant, held from READ through DONE
//   done       out  [NREQ]  one-cycle completion pulse to the granted requester
//   rd         out  read strobe (READ and DLY)
//   ds         out  data strobe / transaction done (DONE)
//   tout       out  pulse with ds when the retry limit ended the transaction
//   busy       out  high in every state except IDLE
//   state_dbg  out  [4]     one-hot FSM state {DONE, DLY, READ, IDLE}
//
// Handshake: a requester raises req (level) and keeps it up until it sees
// its gnt bit. From then on req is ignored, and the transaction always ends
// with a one-cycle done pulse on that requester's bit, unless reset
// intervenes. A requester that holds req through DONE competes again in the
// next IDLE cycle under round-robin order.
//
// Every output is decoded from flops only. No input reaches an output in the
// same cycle.
// -----------------------------------------------------------------------------
module fsm1_rd_arbiter #(
    parameter int NREQ   = 4,
    parameter int MAX_WS = 15
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] req,
    input  logic            ws,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            rd,
    output logic            ds,
    output logic            tout,
    output logic            busy,
    output logic [3:0]      state_dbg
);

    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(MAX_WS + 1);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_READ = 4'b0010,
        S_DLY  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [NREQ-1:0] gnt_q;
    logic [PW-1:0]   ptr_q;
    logic [WW-1:0]   wcnt_q;
    logic            tout_q;

    logic            any_req;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0]   nxt_ptr;
    logic            start;
    logic            retry;
    logic            lim_hit;

    assign any_req = |req;
    assign start   = (state_q == S_IDLE) && any_req;
    // A wait state on the last allowed retry ends the transaction
    // instead of looping back to READ.
    assign retry   = (state_q == S_DLY) && ws && (wcnt_q <  WW'(MAX_WS));
    assign lim_hit = (state_q == S_DLY) && ws && (wcnt_q == WW'(MAX_WS));

    // Round-robin search: ptr, ptr+1, ... modulo NREQ. The first set bit wins.
    always_comb begin
        int idx;
        idx       = 0;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        int nxt;
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        nxt             = int'(win_idx) + 1;
        if (nxt >= NREQ) nxt = 0;
        nxt_ptr         = PW'(nxt);
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = any_req ? S_READ : S_IDLE;
            S_READ:  state_d = S_DLY;
            S_DLY:   state_d = retry ? S_READ : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, round-robin pointer, retry counter and timeout flag.
    // gnt_q is cleared on leaving DONE, so gnt reads zero in IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gnt_q  <= '0;
            ptr_q  <= '0;
            wcnt_q <= '0;
            tout_q <= 1'b0;
        end else begin
            tout_q <= lim_hit;
            if (start) begin
                gnt_q  <= win_oh;
                ptr_q  <= nxt_ptr;
                wcnt_q <= '0;
            end else if (retry) begin
                wcnt_q <= wcnt_q + WW'(1);
            end else if (state_q == S_DONE) begin
                gnt_q  <= '0;
            end
        end
    end

    // Output decode (flop-only).
    always_comb begin
        rd        = (state_q == S_READ) || (state_q == S_DLY);
        ds        = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        gnt       = gnt_q;
        done      = (state_q == S_DONE) ? gnt_q : '0;
        tout      = tout_q;
        state_dbg = state_q;
    end

endmodule
